// File: rtl/sra_pkg.sv
// ---------------------------------------------------------------------------
// sra_pkg -- shared definitions for the square-root-approximation engine.
//
// Contents:
//   sra_state_e   : FSM state encoding (one state per pipeline step)
//   au_op_e       : operation select for the shared arithmetic unit
//   SRA_LATENCY   : clocks from accepted start to the done pulse
//   SRA_X_SHIFT   : shift applied to the larger magnitude (x >> 3)
//   SRA_Y_SHIFT   : shift applied to the smaller magnitude (y >> 1)
// ---------------------------------------------------------------------------
package sra_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ABS   = 3'd1,
        S_ORDER = 3'd2,
        S_SHIFT = 3'd3,
        S_SUB   = 3'd4,
        S_ADD   = 3'd5,
        S_MAX   = 3'd6,
        S_DONE  = 3'd7
    } sra_state_e;

    typedef enum logic [1:0] {
        AU_ADD = 2'd0,
        AU_SUB = 2'd1,
        AU_MAX = 2'd2
    } au_op_e;

    localparam int SRA_LATENCY = 8;
    localparam int SRA_X_SHIFT = 3;
    localparam int SRA_Y_SHIFT = 1;

endpackage

// File: rtl/sra_engine_if.sv
// ---------------------------------------------------------------------------
// sra_engine_if -- request/result bundle of sra_engine.
//
// Signals:
//   start   : request a computation (honoured only while the engine is idle)
//   in_a    : operand A, signed two's complement, WIDTH bits
//   in_b    : operand B, signed two's complement, WIDTH bits
//   busy    : engine is working on a request
//   done    : one-cycle pulse when result has been updated
//   result  : unsigned approximation of sqrt(A^2 + B^2), WIDTH+1 bits
//
// Modports: master drives the request, slave (the engine) drives the status.
// ---------------------------------------------------------------------------
interface sra_engine_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;

    modport master (
        output start, in_a, in_b,
        input  busy, done, result
    );

    modport slave (
        input  start, in_a, in_b,
        output busy, done, result
    );
endinterface

// File: rtl/sra_au.sv
// ---------------------------------------------------------------------------
// sra_au -- combinational add / subtract / maximum unit, W bits unsigned.
// Shared by the SUB, ADD and MAX steps of sra_engine.
//
// Ports:
//   op_i : operation select (AU_ADD, AU_SUB, AU_MAX)
//   a_i  : first operand
//   b_i  : second operand
//   y_o  : a+b, a-b or max(a,b)
// ---------------------------------------------------------------------------
module sra_au
    import sra_pkg::*;
#(
    parameter int W = 18
) (
    input  au_op_e       op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives y_o;
        // a missed branch in combinational logic would otherwise infer a latch.
        y_o = '0;
        case (op_i)
            AU_ADD:  y_o = a_i + b_i;
            AU_SUB:  y_o = a_i - b_i;
            AU_MAX:  y_o = (a_i > b_i) ? a_i : b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/sra_engine.sv
// ---------------------------------------------------------------------------
// sra_engine -- multi-cycle alpha-max-plus-beta-min magnitude estimator.
//
//   x = max(|A|,|B|), y = min(|A|,|B|)
//   t = (x - (x>>3)) + (y>>1),  result = max(t, x)
//
// One FSM step per clock: IDLE, ABS, ORDER, SHIFT, SUB, ADD, MAX, DONE.
// A request accepted at edge k produces done (and a valid result) in the
// cycle after edge k+7; a new request may be accepted in that same cycle.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (wins over start)
//   bus  : sra_engine_if.slave (start/in_a/in_b in, busy/done/result out)
//
// Build option:
//   SRA_ROUND_EN : when defined the shift terms round half up,
//                  (x+4)>>3 and (y+1)>>1; otherwise they truncate.
// ---------------------------------------------------------------------------
module sra_engine
    import sra_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    sra_engine_if.slave     bus
);

    // Internal datapath width: |most-negative| = 2^(WIDTH-1) and
    // t <= 1.375 * 2^(WIDTH-1), so WIDTH+2 bits never overflows.
    localparam int IW = WIDTH + 2;

    sra_state_e       state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    abs_a_q, abs_b_q;
    logic [IW-1:0]    x_q, y_q;
    logic [IW-1:0]    xs_q, ys_q;
    logic [IW-1:0]    t_q;
    logic [WIDTH:0]   result_q;
    logic             busy_q;
    logic             done_q;

    logic [IW-1:0]    a_ext, b_ext;
    logic [IW-1:0]    abs_a_d, abs_b_d;
    logic [IW-1:0]    x_d, y_d;
    logic [IW-1:0]    xs_d, ys_d;

    au_op_e           au_op;
    logic [IW-1:0]    au_a, au_b, au_y;
    logic             unused_msb;

    // ---------------- magnitude / ordering / shift terms ----------------
    // Sign-extend to IW bits first so negating the most-negative operand
    // yields +2^(WIDTH-1) rather than wrapping.
    assign a_ext   = {{2{a_q[WIDTH-1]}}, a_q};
    assign b_ext   = {{2{b_q[WIDTH-1]}}, b_q};
    assign abs_a_d = a_q[WIDTH-1] ? -a_ext : a_ext;
    assign abs_b_d = b_q[WIDTH-1] ? -b_ext : b_ext;

    assign x_d = (abs_a_q >= abs_b_q) ? abs_a_q : abs_b_q;
    assign y_d = (abs_a_q >= abs_b_q) ? abs_b_q : abs_a_q;

`ifdef SRA_ROUND_EN
    // Round half up: add half of the divisor before shifting.
    localparam logic [IW-1:0] X_RND = IW'(1) << (SRA_X_SHIFT - 1);
    localparam logic [IW-1:0] Y_RND = IW'(1) << (SRA_Y_SHIFT - 1);
    assign xs_d = (x_q + X_RND) >> SRA_X_SHIFT;
    assign ys_d = (y_q + Y_RND) >> SRA_Y_SHIFT;
`else
    assign xs_d = x_q >> SRA_X_SHIFT;
    assign ys_d = y_q >> SRA_Y_SHIFT;
`endif

    // ---------------- shared arithmetic unit ----------------
    // Operand steering by state: SUB x-xs, ADD t+ys, MAX max(t,x).
    always_comb begin
        au_op = AU_ADD;
        au_a  = '0;
        au_b  = '0;
        case (state_q)
            S_SUB: begin
                au_op = AU_SUB;
                au_a  = x_q;
                au_b  = xs_q;
            end
            S_ADD: begin
                au_op = AU_ADD;
                au_a  = t_q;
                au_b  = ys_q;
            end
            S_MAX: begin
                au_op = AU_MAX;
                au_a  = t_q;
                au_b  = x_q;
            end
            default: begin
                au_op = AU_ADD;
                au_a  = '0;
                au_b  = '0;
            end
        endcase
    end

    sra_au #(
        .W (IW)
    ) u_au (
        .op_i (au_op),
        .a_i  (au_a),
        .b_i  (au_b),
        .y_o  (au_y)
    );

    // max(t,x) < 2^(WIDTH+1), so the top internal bit is always zero.
    assign unused_msb = au_y[IW-1];

    // ---------------- FSM with registered outputs ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            abs_a_q  <= '0;
            abs_b_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            xs_q     <= '0;
            ys_q     <= '0;
            t_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        busy_q  <= 1'b1;
                        state_q <= S_ABS;
                    end
                end
                S_ABS: begin
                    abs_a_q <= abs_a_d;
                    abs_b_q <= abs_b_d;
                    state_q <= S_ORDER;
                end
                S_ORDER: begin
                    x_q     <= x_d;
                    y_q     <= y_d;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    xs_q    <= xs_d;
                    ys_q    <= ys_d;
                    state_q <= S_SUB;
                end
                S_SUB: begin
                    t_q     <= au_y;
                    state_q <= S_ADD;
                end
                S_ADD: begin
                    t_q     <= au_y;
                    state_q <= S_MAX;
                end
                S_MAX: begin
                    result_q <= au_y[WIDTH:0];
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    // done rises together with the return to IDLE, so the
                    // pulse lines up with the cycle that can accept a new start.
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_sra_engine.sv
// ---------------------------------------------------------------------------
// tb_sra_engine -- self-checking bench for sra_engine (WIDTH = 16).
// Define SRA_ROUND_EN for both bench and RTL to check the rounding build.
// ---------------------------------------------------------------------------
module tb_sra_engine;
    import sra_pkg::*;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    sra_engine_if #(.WIDTH(WIDTH)) bus ();

    sra_engine #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint a;
        longint b;
        longint exp;
        string  name;
    } vec_t;

    vec_t vecs [10];

    // Reference: the magnitude formula evaluated directly on integers.
    function automatic longint model(input longint a, input longint b);
        longint ma, mb, x, y, xs, ys, t;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        x  = (ma > mb) ? ma : mb;
        y  = (ma > mb) ? mb : ma;
`ifdef SRA_ROUND_EN
        xs = (x + 4) / 8;
        ys = (y + 1) / 2;
`else
        xs = x / 8;
        ys = y / 2;
`endif
        t = x - xs + ys;
        return (t > x) ? t : x;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge. Issues one request, optionally scrambles start and
    // the operands while busy, then checks latency, busy, result and that
    // nothing was queued.
    task automatic do_op(input longint a, input longint b, input bit junk, input string name);
        longint exp;
        int     done_at;
        int     pulses;
        bit     busy_ok;
        exp     = model(a, b);
        done_at = 0;
        pulses  = 0;
        busy_ok = 1'b1;
        bus.start = 1'b1;
        bus.in_a  = WIDTH'(a);
        bus.in_b  = WIDTH'(b);
        for (int c = 1; c <= SRA_LATENCY; c++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (done_at == 0) done_at = c;
            end
            if (bus.busy !== (c < SRA_LATENCY)) busy_ok = 1'b0;
            if (c == SRA_LATENCY || !junk) begin
                bus.start = 1'b0;
            end else begin
                bus.start = 1'($urandom_range(1, 0));
                bus.in_a  = WIDTH'($urandom);
                bus.in_b  = WIDTH'($urandom);
            end
        end
        check({name, "_done_cycle"}, done_at, SRA_LATENCY);
        check({name, "_done_pulses"}, pulses, 1);
        check({name, "_busy_profile"}, busy_ok, 1);
        check({name, "_result"}, longint'(bus.result), exp);
        @(negedge clk);
        check({name, "_idle_after"}, {bus.busy, bus.done}, 0);
        check({name, "_result_hold"}, longint'(bus.result), exp);
    endtask

    initial begin
        logic signed [WIDTH-1:0] ra, rb;
        longint exp_c;
        int     pulses, misplaced;

        bus.start = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;

        // Expected values worked out from the formula by hand.
        vecs[0] = '{3, 4, 5, "v_3_4"};
        vecs[1] = '{-300, 400, 500, "v_m300_400"};
        vecs[2] = '{400, -300, 500, "v_400_m300"};
        vecs[3] = '{-32768, 0, 32768, "v_min_0"};
        vecs[4] = '{-32768, -32768, 45056, "v_min_min"};
`ifdef SRA_ROUND_EN
        vecs[5] = '{12, 6, 13, "v_12_6"};
`else
        vecs[5] = '{12, 6, 14, "v_12_6"};
`endif
        vecs[6] = '{0, 0, 0, "v_zero"};
        vecs[7] = '{32767, 32767, 45055, "v_max_max"};
        vecs[8] = '{-1, 0, 1, "v_m1_0"};
        vecs[9] = '{0, -7, 7, "v_0_m7"};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_done", longint'(bus.done), 0);
        check("reset_result", longint'(bus.result), 0);

        // First request issued in the first cycle after reset releases.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check({vecs[i].name, "_table"}, model(vecs[i].a, vecs[i].b), vecs[i].exp);
            do_op(vecs[i].a, vecs[i].b, 1'b0, vecs[i].name);
        end

        // Randomized requests with starts pulsed and operands changed while busy.
        for (int i = 0; i < 150; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(7, 0))
                0: ra = {1'b1, {(WIDTH-1){1'b0}}};
                1: rb = {1'b0, {(WIDTH-1){1'b1}}};
                2: rb = '0;
                default: ;
            endcase
            do_op(longint'(ra), longint'(rb), 1'b1, "rand");
        end

        // start held high: one done every SRA_LATENCY cycles.
        bus.start = 1'b1;
        bus.in_a  = WIDTH'(100);
        bus.in_b  = WIDTH'(-75);
        exp_c     = model(100, -75);
        pulses    = 0;
        misplaced = 0;
        for (int c = 1; c <= 5 * SRA_LATENCY; c++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (c % SRA_LATENCY != 0) misplaced++;
            end
        end
        bus.start = 1'b0;
        check("hold_start_pulses", pulses, 5);
        check("hold_start_spacing", misplaced, 0);
        check("hold_start_result", longint'(bus.result), exp_c);
        @(negedge clk);
        check("hold_start_stop", longint'(bus.busy), 0);

        // Reset while in SUB aborts the computation.
        bus.start = 1'b1;
        bus.in_a  = WIDTH'(1000);
        bus.in_b  = WIDTH'(2000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_result", longint'(bus.result), 0);
        rst = 1'b0;
        do_op(-1234, 567, 1'b0, "after_abort");

        // Reset wins over a simultaneous start.
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("rst_priority_busy", longint'(bus.busy), 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (SRA_LATENCY) begin
            @(negedge clk);
            check("rst_priority_no_done", longint'(bus.done), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
